bp_cac_coh_link_arbiter: RTL and testbench

//  Wormhole-aware round-robin arbiter that lets num_req_p accelerator-side coherence

---
 rtl/bp_cac_coh_link_arbiter.sv | 179 +++++++++++++++++
 tb/tb_bp_cac_coh_link_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cac_coh_link_arbiter.sv
// ---------------------------------------------------------------------------
// bp_cac_coh_link_arbiter
//
// Wormhole-aware round-robin arbiter that merges num_req_p coherence flit
// sources onto one ready-and NoC link. A grant is taken on a header flit and
// held until the last body flit of that packet is accepted, so packets from
// different sources never interleave. The selected flit is passed through
// combinationally: there is no buffering and no added latency.
//
// Optional feature (compile-time macro):
//   BP_CAC_ARB_STATS_EN  - when defined, pkt_count_o is a 32-bit wrapping
//                          count of completed packets; otherwise it is tied
//                          to zero and no counter state exists.
//
// Ports:
//   coh_clk_i    in   1                       clock
//   coh_reset_i  in   1                       synchronous, active-high reset
//   v_i          in   num_req_p               per-requester flit valid
//   data_i       in   num_req_p*flit_width_p  per-requester flit (req i at
//                                             [i*flit_width_p +: flit_width_p])
//   ready_and_o  out  num_req_p               per-requester ready (ready-and)
//   v_o          out  1                       link flit valid
//   data_o       out  flit_width_p            link flit
//   ready_and_i  in   1                       link ready
//   grant_o      out  num_req_p               one-hot current grant, 0 if none
//   locked_o     out  1                       high while mid-packet
//   pkt_count_o  out  32                      completed packet count
// ---------------------------------------------------------------------------
module bp_cac_coh_link_arbiter #(
    parameter int unsigned num_req_p    = 4,
    parameter int unsigned flit_width_p = 64,
    parameter int unsigned len_width_p  = 4,
    parameter int unsigned len_lsb_p    = 8
) (
    input  logic                              coh_clk_i,
    input  logic                              coh_reset_i,
    input  logic [num_req_p-1:0]              v_i,
    input  logic [num_req_p*flit_width_p-1:0] data_i,
    output logic [num_req_p-1:0]              ready_and_o,
    output logic                              v_o,
    output logic [flit_width_p-1:0]           data_o,
    input  logic                              ready_and_i,
    output logic [num_req_p-1:0]              grant_o,
    output logic                              locked_o,
    output logic [31:0]                       pkt_count_o
);

    localparam int unsigned owner_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    typedef enum logic {
        e_idle,
        e_locked
    } state_e;

    state_e                  state_r, state_n;
    logic [owner_w_lp-1:0]   owner_r, owner_n;
    logic [owner_w_lp-1:0]   last_r,  last_n;
    logic [len_width_p-1:0]  cnt_r,   cnt_n;

    logic [owner_w_lp-1:0]   cand;
    logic [owner_w_lp-1:0]   winner;
    logic                    found;
    logic [owner_w_lp-1:0]   sel;
    logic                    sel_any;
    logic                    sel_v;
    logic                    hs;
    logic [len_width_p-1:0]  hdr_len;

    // Round-robin scan starting just after the last packet-completing
    // requester; the first valid one found wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 1; i <= num_req_p; i++) begin
            cand = owner_w_lp'((32'(last_r) + i) % num_req_p);
            if (!found && v_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Output mux: while locked the owner keeps the link even when it bubbles.
    always_comb begin
        sel         = (state_r == e_locked) ? owner_r : winner;
        sel_any     = (state_r == e_locked) ? 1'b1 : found;
        sel_v       = v_i[sel];
        v_o         = 1'b0;
        data_o      = '0;
        grant_o     = '0;
        ready_and_o = '0;
        if (!coh_reset_i && sel_any) begin
            grant_o[sel]     = 1'b1;
            ready_and_o[sel] = ready_and_i;
            v_o              = sel_v;
            if (sel_v) begin
                data_o = data_i[32'(sel)*flit_width_p +: flit_width_p];
            end
        end
        locked_o = !coh_reset_i && (state_r == e_locked);
    end

    assign hs      = v_o & ready_and_i;
    assign hdr_len = data_o[len_lsb_p +: len_width_p];

    always_comb begin
        state_n = state_r;
        owner_n = owner_r;
        cnt_n   = cnt_r;
        last_n  = last_r;
        if (hs) begin
            case (state_r)
                e_idle: begin
                    if (hdr_len == '0) begin
                        last_n = winner;
                    end else begin
                        owner_n = winner;
                        cnt_n   = hdr_len;
                        state_n = e_locked;
                    end
                end
                e_locked: begin
                    // cnt_r is always >= 1 here, so no underflow.
                    cnt_n = cnt_r - 1'b1;
                    if (cnt_r == len_width_p'(1)) begin
                        last_n  = owner_r;
                        state_n = e_idle;
                    end
                end
                default: state_n = e_idle;
            endcase
        end
    end

    always_ff @(posedge coh_clk_i) begin
        if (coh_reset_i) begin
            state_r <= e_idle;
            owner_r <= '0;
            cnt_r   <= '0;
            last_r  <= owner_w_lp'(num_req_p - 1);
        end else begin
            state_r <= state_n;
            owner_r <= owner_n;
            cnt_r   <= cnt_n;
            last_r  <= last_n;
        end
    end

`ifdef BP_CAC_ARB_STATS_EN
    logic        pkt_done;
    logic [31:0] pkt_count_r;

    // A packet completes on a zero-length header or on the tail body flit.
    always_comb begin
        pkt_done = 1'b0;
        if (hs) begin
            if (state_r == e_idle) begin
                pkt_done = (hdr_len == '0);
            end else begin
                pkt_done = (cnt_r == len_width_p'(1));
            end
        end
    end

    always_ff @(posedge coh_clk_i) begin
        if (coh_reset_i) begin
            pkt_count_r <= '0;
        end else if (pkt_done) begin
            pkt_count_r <= pkt_count_r + 32'd1;
        end
    end

    assign pkt_count_o = pkt_count_r;
`else
    assign pkt_count_o = '0;
`endif

endmodule

// File: tb/tb_bp_cac_coh_link_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bp_cac_coh_link_arbiter
//
// Self-checking bench: per-requester flit sources feed the arbiter, and a
// packet-level reference model predicts every link-side output each cycle.
// Directed scenarios cover round-robin order, wormhole locking, link stall,
// owner bubbles, reset mid-packet and the packet counter; a long randomized
// run follows.
// ---------------------------------------------------------------------------
module tb_bp_cac_coh_link_arbiter;

    localparam int NR    = 4;
    localparam int FW    = 64;
    localparam int LW    = 4;
    localparam int LL    = 8;
    localparam int DEPTH = 1024;

`ifdef BP_CAC_ARB_STATS_EN
    localparam bit stats_en = 1'b1;
`else
    localparam bit stats_en = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     v_i;
    logic [NR*FW-1:0]  data_i;
    logic [NR-1:0]     ready_and_o;
    logic              v_o;
    logic [FW-1:0]     data_o;
    logic              ready_and_i;
    logic [NR-1:0]     grant_o;
    logic              locked_o;
    logic [31:0]       pkt_count_o;

    always #5 clk = ~clk;

    bp_cac_coh_link_arbiter #(
        .num_req_p   (NR),
        .flit_width_p(FW),
        .len_width_p (LW),
        .len_lsb_p   (LL)
    ) dut (
        .coh_clk_i  (clk),
        .coh_reset_i(rst),
        .v_i        (v_i),
        .data_i     (data_i),
        .ready_and_o(ready_and_o),
        .v_o        (v_o),
        .data_o     (data_o),
        .ready_and_i(ready_and_i),
        .grant_o    (grant_o),
        .locked_o   (locked_o),
        .pkt_count_o(pkt_count_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Flit sources: one ring of pending flits per requester.
    logic [FW-1:0] src_mem [NR][DEPTH];
    int            src_wr [NR];
    int            src_rd [NR];
    logic [NR-1:0] hold_off;

    // Packet-level reference: who owns the link, body flits still due,
    // and which requester finished the most recent packet.
    bit          m_locked;
    int          m_owner;
    int          m_rem;
    int          m_last;
    int unsigned m_pkts;

    logic [NR-1:0] obs_grant;
    logic [NR-1:0] obs_rdy;
    logic          obs_v;
    logic          obs_locked;

    task automatic push_pkt(input int r, input int len);
        logic [FW-1:0] f;
        for (int k = 0; k <= len; k++) begin
            f = {$urandom, $urandom};
            if (k == 0) f[LL +: LW] = LW'(len);
            src_mem[r][src_wr[r] % DEPTH] = f;
            src_wr[r]++;
        end
    endtask

    task automatic flush_sources();
        for (int r = 0; r < NR; r++) src_rd[r] = src_wr[r];
    endtask

    task automatic step(input bit do_rst, input bit rdy, input int vpct);
        bit            ev;
        logic [FW-1:0] ed;
        logic [NR-1:0] eg;
        logic [NR-1:0] er;
        int            w;
        int            best_d;
        int            d;

        rst         = do_rst;
        ready_and_i = rdy;
        for (int r = 0; r < NR; r++) begin
            if (src_rd[r] < src_wr[r] && !hold_off[r] && $urandom_range(99) < vpct) begin
                v_i[r]             = 1'b1;
                data_i[r*FW +: FW] = src_mem[r][src_rd[r] % DEPTH];
            end else begin
                v_i[r]             = 1'b0;
                data_i[r*FW +: FW] = {$urandom, $urandom};
            end
        end

        @(negedge clk);

        ev = 1'b0; ed = '0; eg = '0; er = '0; w = -1;
        if (!do_rst) begin
            if (m_locked) begin
                w = m_owner;
            end else begin
                // Priority = distance past the last completing requester.
                best_d = NR;
                for (int r = 0; r < NR; r++) begin
                    d = (r - m_last - 1 + 2*NR) % NR;
                    if (v_i[r] && d < best_d) begin
                        best_d = d;
                        w      = r;
                    end
                end
            end
            if (w >= 0) begin
                eg[w] = 1'b1;
                er[w] = rdy;
                ev    = v_i[w];
                if (ev) ed = data_i[w*FW +: FW];
            end
        end

        check_eq("v_o",         64'(v_o),         64'(ev));
        check_eq("data_o",      data_o,           ed);
        check_eq("grant_o",     64'(grant_o),     64'(eg));
        check_eq("ready_and_o", 64'(ready_and_o), 64'(er));
        check_eq("locked_o",    64'(locked_o),    64'(m_locked && !do_rst));
        check_eq("pkt_count_o", 64'(pkt_count_o), stats_en ? 64'(m_pkts) : 64'd0);

        obs_grant  = grant_o;
        obs_rdy    = ready_and_o;
        obs_v      = v_o;
        obs_locked = locked_o;

        if (do_rst) begin
            m_locked = 1'b0;
            m_rem    = 0;
            m_last   = NR - 1;
            m_pkts   = 0;
            flush_sources();
        end else if (ev && rdy) begin
            src_rd[w]++;
            if (!m_locked) begin
                if (ed[LL +: LW] == '0) begin
                    m_last = w;
                    m_pkts++;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = w;
                    m_rem    = int'(ed[LL +: LW]);
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_locked = 1'b0;
                    m_last   = w;
                    m_pkts++;
                end
            end
        end

        @(posedge clk);
        #1;
    endtask

    int lcnt;
    int lens [10] = '{0, 3, 1, 0, 15, 2, 0, 5, 1, 7};

    initial begin
        rst         = 1'b1;
        v_i         = '0;
        data_i      = '0;
        ready_and_i = 1'b0;
        hold_off    = '0;
        for (int r = 0; r < NR; r++) begin
            src_wr[r] = 0;
            src_rd[r] = 0;
        end
        m_locked = 1'b0; m_owner = 0; m_rem = 0; m_last = NR - 1; m_pkts = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        step(1'b1, 1'b1, 100);
        check_eq("reset_grant",  64'(obs_grant),  64'd0);
        check_eq("reset_locked", 64'(obs_locked), 64'd0);

        // Round robin of single-flit packets: 0,1,2,3,0
        for (int r = 0; r < NR; r++) begin
            push_pkt(r, 0);
            push_pkt(r, 0);
        end
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b1, 100);
            check_eq("rr_order", 64'(obs_grant), 64'd1 << (c % NR));
        end
        repeat (6) step(1'b0, 1'b1, 100);

        // Wormhole: req1 4-flit packet, req2 waits and follows immediately
        push_pkt(1, 3);
        push_pkt(2, 0);
        lcnt = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 1'b1, 100);
            if (c < 4) check_eq("wormhole_owner", 64'(obs_grant), 64'd2);
            if (c == 4) check_eq("b2b_grant", 64'(obs_grant), 64'd4);
            if (obs_locked) lcnt++;
        end
        check_eq("locked_cycles", 64'(lcnt), 64'd3);

        // Link stall mid-packet
        push_pkt(0, 4);
        repeat (3) step(1'b0, 1'b1, 100);
        repeat (5) begin
            step(1'b0, 1'b0, 100);
            check_eq("stall_grant", 64'(obs_grant), 64'd1);
            check_eq("stall_rdy",   64'(obs_rdy),   64'd0);
        end
        repeat (3) step(1'b0, 1'b1, 100);

        // Owner bubble while req3 waits
        push_pkt(0, 3);
        step(1'b0, 1'b1, 100);
        push_pkt(3, 0);
        hold_off = 4'b0001;
        repeat (3) begin
            step(1'b0, 1'b1, 100);
            check_eq("bubble_v",     64'(obs_v),     64'd0);
            check_eq("bubble_grant", 64'(obs_grant), 64'd1);
        end
        hold_off = '0;
        repeat (5) step(1'b0, 1'b1, 100);

        // Reset while locked
        push_pkt(2, 7);
        repeat (3) step(1'b0, 1'b1, 100);
        check_eq("pre_reset_locked", 64'(obs_locked), 64'd1);
        step(1'b1, 1'b1, 100);
        push_pkt(0, 0);
        push_pkt(2, 0);
        step(1'b0, 1'b1, 100);
        check_eq("post_reset_locked", 64'(obs_locked), 64'd0);
        check_eq("post_reset_grant",  64'(obs_grant),  64'd1);
        repeat (3) step(1'b0, 1'b1, 100);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            for (int r = 0; r < NR; r++) begin
                if (src_wr[r] - src_rd[r] < 40 && $urandom_range(3) == 0) begin
                    if ($urandom_range(3) == 0) push_pkt(r, int'($urandom_range(15)));
                    else                        push_pkt(r, int'($urandom_range(2)));
                end
            end
            step($urandom_range(599) == 0, $urandom_range(4) != 0, 75);
        end
        repeat (150) step(1'b0, 1'b1, 100);

        // Packet counter over 10 mixed-length packets
        step(1'b1, 1'b1, 100);
        for (int p = 0; p < 10; p++) push_pkt(p % NR, lens[p]);
        repeat (60) step(1'b0, 1'b1, 100);
        check_eq("stats_10", 64'(pkt_count_o), stats_en ? 64'd10 : 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
